// File: rtl/glb_pe_bus_receiver.sv
// glb_pe_bus_receiver
// PE-side endpoint of the global-buffer-to-PE bus. It accepts words tagged for
// this PE column, queues them in a small FIFO and frames them into kernel
// windows of kernel_size words. It flags the last word of each window and
// pulses row_done once that window has fully drained.
// Optional build macro RX_STATS_EN adds a saturating rx_count of accepted words.
//
// Handshake: a bus word transfers on a clock edge where match & m2b_ready.
// A PE word transfers where pe_valid & pe_ready. Both sides are valid/ready.
// The bus side cannot stall, so a matched word that sees m2b_ready low is
// dropped and sets the sticky overflow flag.
module glb_pe_bus_receiver #(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_COL    = 4,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [DATA_WIDTH-1:0]     ifmap_data_B2M,
    input  logic [DATA_WIDTH-1:0]     fltr_data_B2M,
    input  logic [2*DATA_WIDTH-1:0]   psum_data_B2M,
    input  logic [((NUM_COL>1)?$clog2(NUM_COL):1)-1:0] ID,
    input  logic [((NUM_COL>1)?$clog2(NUM_COL):1)-1:0] TAG,
    input  logic                      READY,
    input  logic                      CASTER_EN,
    input  logic [7:0]                kernel_size,
    output logic                      m2b_ready,
    output logic                      pe_valid,
    input  logic                      pe_ready,
    output logic [DATA_WIDTH-1:0]     pe_ifmap,
    output logic [DATA_WIDTH-1:0]     pe_fltr,
    output logic [2*DATA_WIDTH-1:0]   pe_psum,
    output logic                      pe_last,
    output logic                      row_done,
    output logic                      overflow,
    output logic [1:0]                dbg_state
`ifdef RX_STATS_EN
    ,
    output logic [15:0]               rx_count
`endif
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int EW = 4*DATA_WIDTH + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RECV  = 2'd1,
        S_FLUSH = 2'd2
    } state_t;

    state_t          r_state;
    logic [7:0]      r_k;
    logic [7:0]      r_wcnt;
    logic [EW-1:0]   r_mem [FIFO_DEPTH];
    logic [PW-1:0]   r_wr_ptr;
    logic [PW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;
    logic            r_row_done;
    logic            r_overflow;

    logic            w_match;
    logic            w_ignore;
    logic            w_ready;
    logic            w_accept;
    logic            w_drop;
    logic            w_pop;
    logic            w_last;
    logic [EW-1:0]   w_entry;
    logic            w_head_last;

    // An idle receiver with kernel_size 0 has no window to open, so matched
    // words are silently ignored rather than counted as drops.
    assign w_match  = CASTER_EN & READY & (ID == TAG);
    assign w_ignore = (r_state == S_IDLE) & (kernel_size == 8'd0);
    // Readiness comes from the registered count: a full FIFO refuses a push
    // even if the head pops in the same cycle.
    assign w_ready  = ~rst & (r_state != S_FLUSH) & (r_count < CW'(FIFO_DEPTH));
    assign w_accept = w_match & w_ready & ~w_ignore;
    assign w_drop   = w_match & ~w_ready & ~w_ignore;
    assign w_pop    = (r_count != '0) & pe_ready;
    assign w_last   = (r_state == S_IDLE) ? (kernel_size == 8'd1)
                                          : (r_wcnt == r_k - 8'd1);
    assign w_entry  = {ifmap_data_B2M, fltr_data_B2M, psum_data_B2M, w_last};

    assign m2b_ready = w_ready;
    assign pe_valid  = (r_count != '0);
    assign {pe_ifmap, pe_fltr, pe_psum, w_head_last} = r_mem[r_rd_ptr];
    assign pe_last   = pe_valid & w_head_last;
    assign row_done  = r_row_done;
    assign overflow  = r_overflow;
    assign dbg_state = r_state;

    // Receive FIFO storage, pointers and occupancy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_accept) begin
                r_mem[r_wr_ptr] <= w_entry;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_accept && !w_pop)      r_count <= r_count + 1'b1;
            else if (!w_accept && w_pop) r_count <= r_count - 1'b1;
        end
    end

    // Window framing FSM: open on the first accept, close on the K-th word,
    // then wait for the FIFO to drain before announcing row_done.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_k        <= 8'd0;
            r_wcnt     <= 8'd0;
            r_row_done <= 1'b0;
        end else begin
            r_row_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_k     <= kernel_size;
                        r_wcnt  <= 8'd1;
                        r_state <= (kernel_size == 8'd1) ? S_FLUSH : S_RECV;
                    end
                end
                S_RECV: begin
                    if (w_accept) begin
                        r_wcnt <= r_wcnt + 8'd1;
                        if (r_wcnt == r_k - 8'd1) r_state <= S_FLUSH;
                    end
                end
                S_FLUSH: begin
                    if (r_count == '0) begin
                        r_row_done <= 1'b1;
                        r_state    <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Sticky drop flag; only reset clears it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)         r_overflow <= 1'b0;
        else if (w_drop) r_overflow <= 1'b1;
    end

`ifdef RX_STATS_EN
    logic [15:0] r_rx_count;
    assign rx_count = r_rx_count;

    // Saturating count of accepted words since reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                    r_rx_count <= 16'd0;
        else if (w_accept && r_rx_count != 16'hFFFF) r_rx_count <= r_rx_count + 16'd1;
    end
`endif

endmodule

// File: tb/tb_glb_pe_bus_receiver.sv
// tb_glb_pe_bus_receiver
// Directed scenarios followed by random traffic. Every cycle the DUT is
// compared against a transaction-level model: a queue of expected FIFO
// entries plus simple window bookkeeping.
module tb_glb_pe_bus_receiver;

    localparam int DW    = 16;
    localparam int DEPTH = 8;
    localparam int EW    = 4*DW + 1;

    // clock / reset
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [DW-1:0]   ifmap_data_B2M = '0;
    logic [DW-1:0]   fltr_data_B2M  = '0;
    logic [2*DW-1:0] psum_data_B2M  = '0;
    logic [1:0]      ID  = '0;
    logic [1:0]      TAG = '0;
    logic            READY = 1'b0;
    logic            CASTER_EN = 1'b0;
    logic [7:0]      kernel_size = '0;
    logic            pe_ready = 1'b0;
    logic            m2b_ready, pe_valid, pe_last, row_done, overflow;
    logic [DW-1:0]   pe_ifmap, pe_fltr;
    logic [2*DW-1:0] pe_psum;
    logic [1:0]      dbg_state;
`ifdef RX_STATS_EN
    logic [15:0]     rx_count;
`endif

    glb_pe_bus_receiver #(.DATA_WIDTH(DW), .NUM_COL(4), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .ifmap_data_B2M(ifmap_data_B2M), .fltr_data_B2M(fltr_data_B2M),
        .psum_data_B2M(psum_data_B2M), .ID(ID), .TAG(TAG), .READY(READY),
        .CASTER_EN(CASTER_EN), .kernel_size(kernel_size),
        .m2b_ready(m2b_ready), .pe_valid(pe_valid), .pe_ready(pe_ready),
        .pe_ifmap(pe_ifmap), .pe_fltr(pe_fltr), .pe_psum(pe_psum),
        .pe_last(pe_last), .row_done(row_done), .overflow(overflow),
        .dbg_state(dbg_state)
`ifdef RX_STATS_EN
        , .rx_count(rx_count)
`endif
    );

    // scoreboard / reference model
    logic [EW-1:0] exp_q[$];
    bit            m_active, m_flush, m_ovf, m_row_done;
    int            m_k, m_got, m_rx;
    int            n_chk = 0, n_err = 0, rd_seen = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_active = 0; m_flush = 0; m_ovf = 0; m_row_done = 0;
        m_k = 0; m_got = 0; m_rx = 0;
    endtask

    // Advance the model across one clock edge using the current inputs.
    task automatic model_advance();
        int  sz;
        bit  rdy, match, ign, lst, rd_next;
        sz      = exp_q.size();
        rdy     = !m_flush && sz < DEPTH;
        match   = CASTER_EN && READY && (ID == TAG);
        ign     = !m_active && !m_flush && kernel_size == 0;
        rd_next = m_flush && sz == 0;
        if (rd_next) m_flush = 0;
        if (sz > 0 && pe_ready) void'(exp_q.pop_front());
        if (match && !ign) begin
            if (rdy) begin
                if (!m_active) begin
                    m_k = kernel_size; m_got = 1;
                end else begin
                    m_got++;
                end
                lst = (m_got == m_k);
                m_active = !lst;
                if (lst) m_flush = 1;
                exp_q.push_back({ifmap_data_B2M, fltr_data_B2M, psum_data_B2M, lst});
                if (m_rx < 65535) m_rx++;
            end else begin
                m_ovf = 1;
            end
        end
        m_row_done = rd_next;
    endtask

    // One cycle: compare outputs, then step model and clock.
    task automatic step();
        logic [EW-1:0] h;
        #1;
        if (rst) model_reset();
        check("m2b_ready", m2b_ready, rst ? 1'b0 : (!m_flush && exp_q.size() < DEPTH));
        check("pe_valid", pe_valid, exp_q.size() > 0);
        check("row_done", row_done, m_row_done);
        check("overflow", overflow, m_ovf);
        if (exp_q.size() > 0) begin
            h = exp_q[0];
            check("pe_ifmap", pe_ifmap, h[EW-1 -: DW]);
            check("pe_fltr",  pe_fltr,  h[EW-1-DW -: DW]);
            check("pe_psum",  pe_psum,  h[2*DW:1]);
            check("pe_last",  pe_last,  h[0]);
        end else begin
            check("pe_last_empty", pe_last, 1'b0);
        end
`ifdef RX_STATS_EN
        check("rx_count", rx_count, m_rx);
`endif
        if (row_done === 1'b1) rd_seen++;
        if (!rst) model_advance();
        @(posedge clk);
        @(negedge clk);
    endtask

    // driver tasks
    task automatic drive(input bit en, input bit rdy, input logic [1:0] tag,
                         input logic [DW-1:0] a, input bit per);
        CASTER_EN = en; READY = rdy; TAG = tag; pe_ready = per;
        ifmap_data_B2M = a; fltr_data_B2M = ~a; psum_data_B2M = {a, a ^ 16'h5A5A};
    endtask

    task automatic idle(input int n, input bit per);
        for (int i = 0; i < n; i++) begin
            drive(0, 0, TAG, 16'h0, per);
            step();
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        model_reset();
        // reset state
        do_reset();
        check("dbg_state_reset", dbg_state, 2'd0);
        check("pe_ifmap_reset", pe_ifmap, 16'h0);

        // scenario 1: three-word window
        ID = 2; kernel_size = 3; rd_seen = 0;
        drive(1, 1, 2, 16'hAAAA, 1); step();
        drive(1, 1, 2, 16'hBBBB, 1); step();
        drive(1, 1, 2, 16'hCCCC, 1); step();
        idle(6, 1);
        check("row_done_pulses", rd_seen, 1);
`ifdef RX_STATS_EN
        check("rx_count_t1", rx_count, 16'd3);
`endif

        // scenario 2: tag mismatch
        ID = 1;
        for (int i = 0; i < 5; i++) begin drive(1, 1, 2, 16'(i), 1); step(); end
        check("state_idle_t2", dbg_state, 2'd0);

        // scenario 3: overflow with PE stalled
        ID = 0; kernel_size = 16;
        for (int i = 0; i < 10; i++) begin drive(1, 1, 0, 16'h100 + 16'(i), 0); step(); end
        check("overflow_t3", overflow, 1'b1);
        idle(10, 1);

        // scenario 4: concurrent push/pop, then full+pop+match
        do_reset();
        kernel_size = 16;
        for (int i = 0; i < 4; i++) begin drive(1, 1, 0, 16'h200 + 16'(i), 0); step(); end
        drive(1, 1, 0, 16'h210, 1); step();
        for (int i = 0; i < 4; i++) begin drive(1, 1, 0, 16'h220 + 16'(i), 0); step(); end
        drive(1, 1, 0, 16'h230, 1); step();
        idle(10, 1);

        // scenario 5: reset mid-window, then a fresh window
        do_reset();
        kernel_size = 4;
        drive(1, 1, 0, 16'h301, 0); step();
        drive(1, 1, 0, 16'h302, 0); step();
        do_reset();
        check("pe_valid_t5", pe_valid, 1'b0);
        kernel_size = 2;
        drive(1, 1, 0, 16'h311, 1); step();
        drive(1, 1, 0, 16'h312, 1); step();
        idle(5, 1);

        // scenario 6: kernel_size 0 ignores matches
        kernel_size = 0;
        for (int i = 0; i < 4; i++) begin drive(1, 1, 0, 16'h400 + 16'(i), 0); step(); end
        check("overflow_t6", overflow, 1'b0);

        // random traffic
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 7) == 0) kernel_size = 8'($urandom_range(0, 5));
            if ($urandom_range(0, 499) == 0) begin
                do_reset();
            end else begin
                drive($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                      2'($urandom_range(0, 3)), 16'($urandom), $urandom_range(0, 2) != 0);
                step();
            end
        end
        idle(20, 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
